img_pad_loader: RTL and testbench
=================================

IMG_PAD_LOADER -- requirements
Module: img_pad_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_SIZE, default 5, raw image side length in pixels.
REQ-003 The block SHALL have parameter FILTER_SIZE, default 3, odd filter side length; PAD=(FILTER_SIZE-1)/2, PADDED=IMG_SIZE+FILTER_SIZE-1.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pix_in  input  DATA_WIDTH  raw pixel, raster order (row-major, column fastest).
REQ-007 pix_valid  input  1  pix_in is valid this cycle.
REQ-008 pix_sof  input  1  qualifies pix_in as first pixel of a frame (row 0, col 0).
REQ-009 pix_ready  output  1  block accepts a pixel this cycle; a pixel is accepted when pix_valid and pix_ready are both high.
REQ-010 padded_img  output  DATA_WIDTH x [0:PADDED-1][0:PADDED-1]  zero-padded frame driven from internal registers.
REQ-011 img_valid  output  1  padded_img holds a complete frame and is stable.
REQ-012 img_done  input  1  consumer has finished with padded_img; releases the buffer.
REQ-013 sof_err  output  1  one-cycle pulse: pix_sof accepted when position was not (0,0).
REQ-014 frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-015 The block SHALL implement states LOAD and HOLD; pix_ready SHALL be high exactly in LOAD (combinational from state).
REQ-016 In LOAD, each accepted pixel SHALL be written to padded_img[row+PAD][col+PAD]; it is visible on padded_img the cycle after acceptance.
REQ-017 Position counters row, col (width $clog2(IMG_SIZE), minimum 1) SHALL advance col first; col wraps IMG_SIZE-1->0 with row incrementing.
REQ-018 Accepting the pixel at (IMG_SIZE-1, IMG_SIZE-1) SHALL, on that same edge, set state=HOLD, img_valid=1, counters=(0,0), and increment frame_cnt.
REQ-019 In HOLD, padded_img SHALL NOT change; pix_valid, pix_in and pix_sof SHALL be ignored.
REQ-020 In HOLD, img_done high SHALL, on that edge, set state=LOAD and img_valid=0; img_done in LOAD SHALL be ignored.
REQ-021 Border cells (any index <PAD or >=PAD+IMG_SIZE) SHALL be zero at all times and never written.
REQ-022 Interior cells SHALL retain previous-frame values until overwritten by the new frame.
REQ-023 An accepted pixel with pix_sof high SHALL be written at (0,0) and set counters to (0,1), regardless of current position (frame restart).
REQ-024 If that restart occurs with counters not at (0,0), sof_err SHALL pulse high for exactly the cycle after acceptance; frame_cnt SHALL be unchanged.
REQ-025 pix_sof is optional: an accepted pixel at position (0,0) without pix_sof SHALL be treated as the start of a frame.
REQ-026 With IMG_SIZE=1, the single accepted pixel SHALL complete a frame (REQ-018 applies immediately).
REQ-027 Latency from last-pixel acceptance edge to img_valid high SHALL be zero additional cycles (registered on that edge); minimum frame-to-frame period SHALL be IMG_SIZE*IMG_SIZE+1 cycles.

Reset
REQ-028 rst high SHALL asynchronously force state=LOAD, counters=(0,0), every padded_img cell=0, img_valid=0, sof_err=0, frame_cnt=0.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial or held frame; the first accepted pixel after release SHALL be written at (0,0).

Structure
REQ-030 A shared package img_pkg SHALL hold default DATA_WIDTH, IMG_SIZE, FILTER_SIZE, PAD/PADDED derivation functions and the state encoding (LOAD=1'b0, HOLD=1'b1), reused by the convolution engine.
REQ-031 The block SHALL be a single module; no sub-module is required, counters and buffer writes are inline.

Verification
REQ-032 Defaults; feed pixels 1..25 back-to-back with sof on the first -> img_valid rises on the edge after pixel 25 is accepted; padded_img[1][1]=1, [5][5]=25, row/col 0 and 6 all zero; frame_cnt=1.
REQ-033 Toggle pix_valid randomly 50% during load -> identical padded_img as REQ-032; pix_ready stays high until the last acceptance.
REQ-034 In HOLD present pix_valid=1, pix_in=8'hFF for 10 cycles, then pulse img_done -> padded_img unchanged throughout, img_valid falls the cycle after img_done, pix_ready returns high.
REQ-035 Send 7 pixels, then pixel 8'h40 with sof -> sof_err single pulse, padded_img[1][1]=8'h40, 24 more pixels complete the frame, frame_cnt increments by exactly 1.
REQ-036 Assert rst after 12 pixels accepted -> all outputs zero asynchronously; subsequent 25 pixels fill a correct frame starting at [1][1].
REQ-037 Run 256 frames -> frame_cnt wraps to 0 on the 256th completion.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default geometry, padding derivation and
// the loader state encoding, also imported by the convolution engine.
package img_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_IMG_SIZE    = 5;
  localparam int DEF_FILTER_SIZE = 3;

  function automatic int pad_of(input int filter_size);
    return (filter_size - 1) / 2;
  endfunction

  function automatic int padded_of(input int img_size, input int filter_size);
    return img_size + filter_size - 1;
  endfunction

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } load_state_e;

endpackage

// File: rtl/img_pad_loader.sv
// Loads a raster-order pixel stream into a zero-padded frame buffer and holds
// the completed frame until the consumer releases it with img_done.
module img_pad_loader
  import img_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IMG_SIZE    = DEF_IMG_SIZE,
  parameter int FILTER_SIZE = DEF_FILTER_SIZE,
  localparam int PAD        = pad_of(FILTER_SIZE),
  localparam int PADDED     = padded_of(IMG_SIZE, FILTER_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] padded_img [0:PADDED-1][0:PADDED-1],
  output logic                  img_valid,
  input  logic                  img_done,
  output logic                  sof_err,
  output logic [7:0]            frame_cnt
);

  localparam int CW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_SIZE - 1);

  load_state_e           state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  img_valid_q, img_valid_d;
  logic                  sof_err_q, sof_err_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [0:IMG_SIZE-1][0:IMG_SIZE-1];
  logic [DATA_WIDTH-1:0] buf_d [0:IMG_SIZE-1][0:IMG_SIZE-1];

  // Write position of the current pixel; a sof pixel is forced to (0,0).
  logic [CW-1:0]         wr_row;
  logic [CW-1:0]         wr_col;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    img_valid_d = img_valid_q;
    sof_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    buf_d       = buf_q;
    wr_row      = row_q;
    wr_col      = col_q;

    case (state_q)
      LOAD: begin
        if (pix_valid) begin
          if (pix_sof) begin
            wr_row    = '0;
            wr_col    = '0;
            sof_err_d = (row_q != '0) || (col_q != '0);
          end
          buf_d[wr_row][wr_col] = pix_in;
          if ((wr_row == LAST_IDX) && (wr_col == LAST_IDX)) begin
            state_d     = HOLD;
            img_valid_d = 1'b1;
            row_d       = '0;
            col_d       = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else if (wr_col == LAST_IDX) begin
            row_d = wr_row + CW'(1);
            col_d = '0;
          end else begin
            row_d = wr_row;
            col_d = wr_col + CW'(1);
          end
        end
      end
      HOLD: begin
        if (img_done) begin
          state_d     = LOAD;
          img_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      row_q       <= '0;
      col_q       <= '0;
      img_valid_q <= 1'b0;
      sof_err_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      img_valid_q <= img_valid_d;
      sof_err_q   <= sof_err_d;
      frame_cnt_q <= frame_cnt_d;
      buf_q       <= buf_d;
    end
  end

  assign pix_ready = (state_q == LOAD);
  assign img_valid = img_valid_q;
  assign sof_err   = sof_err_q;
  assign frame_cnt = frame_cnt_q;

  // Border cells are tied to zero; only the interior has storage.
  for (genvar r = 0; r < PADDED; r++) begin : g_row
    for (genvar c = 0; c < PADDED; c++) begin : g_col
      if ((r >= PAD) && (r < PAD + IMG_SIZE) && (c >= PAD) && (c < PAD + IMG_SIZE)) begin : g_int
        assign padded_img[r][c] = buf_q[r-PAD][c-PAD];
      end else begin : g_border
        assign padded_img[r][c] = '0;
      end
    end
  end

endmodule

// File: tb/tb_img_pad_loader.sv
// Directed bench for img_pad_loader at default geometry (5x5 image, 7x7 padded).
module tb_img_pad_loader;

  logic       clk;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_sof;
  logic       pix_ready;
  logic [7:0] padded_img [0:6][0:6];
  logic       img_valid;
  logic       img_done;
  logic       sof_err;
  logic [7:0] frame_cnt;

  int tests;
  int fails;
  logic [7:0] exp_img [0:6][0:6];

  typedef struct {
    string      name;
    int         r;
    int         c;
    logic [7:0] exp;
  } cell_vec_t;

  cell_vec_t vecs [14];

  img_pad_loader dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .padded_img(padded_img),
    .img_valid (img_valid),
    .img_done  (img_done),
    .sof_err   (sof_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame: interior pixel (r,c) holds base + r*5 + c, border zero.
  task automatic set_frame(input int base, input bit zero);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        exp_img[r][c] = 8'd0;
    if (!zero)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          exp_img[r+1][c+1] = 8'(base + r * 5 + c);
  endtask

  function automatic int frame_diff();
    int n = 0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        if (padded_img[r][c] !== exp_img[r][c]) n++;
    return n;
  endfunction

  task automatic send(input logic [7:0] d, input logic s);
    pix_valid = 1'b1;
    pix_in    = d;
    pix_sof   = s;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = 8'd0;
  endtask

  task automatic release_frame();
    img_done = 1'b1;
    @(posedge clk);
    #1;
    img_done = 1'b0;
  endtask

  initial begin
    int k;
    int cycles;
    int ready_drop;
    int errs;
    logic v;

    tests = 0;
    fails = 0;
    vecs[0]  = '{"corner_00", 0, 0, 8'd0};
    vecs[1]  = '{"p11",       1, 1, 8'd1};
    vecs[2]  = '{"p15",       1, 5, 8'd5};
    vecs[3]  = '{"p24",       2, 4, 8'd9};
    vecs[4]  = '{"p33",       3, 3, 8'd13};
    vecs[5]  = '{"p42",       4, 2, 8'd17};
    vecs[6]  = '{"p51",       5, 1, 8'd21};
    vecs[7]  = '{"p55",       5, 5, 8'd25};
    vecs[8]  = '{"top_03",    0, 3, 8'd0};
    vecs[9]  = '{"right_36",  3, 6, 8'd0};
    vecs[10] = '{"bottom_62", 6, 2, 8'd0};
    vecs[11] = '{"left_40",   4, 0, 8'd0};
    vecs[12] = '{"corner_66", 6, 6, 8'd0};
    vecs[13] = '{"p21",       2, 1, 8'd6};

    rst       = 1'b1;
    pix_in    = 8'd0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    img_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    set_frame(0, 1'b1);
    chk("rst_img_valid", img_valid, 0);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_sof_err",   sof_err,   0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame",     frame_diff(), 0);
    rst = 1'b0;

    // Frame of 1..25, back-to-back, sof on the first pixel.
    send(8'd1, 1'b1);
    chk("first_visible", padded_img[1][1], 8'd1);
    chk("first_sof_err", sof_err, 0);
    for (int i = 2; i <= 24; i++) send(8'(i), 1'b0);
    chk("pre_last_valid", img_valid, 0);
    chk("pre_last_ready", pix_ready, 1);
    send(8'd25, 1'b0);
    chk("last_img_valid", img_valid, 1);
    chk("last_pix_ready", pix_ready, 0);
    chk("last_frame_cnt", frame_cnt, 1);
    set_frame(1, 1'b0);
    chk("frame1", frame_diff(), 0);
    for (int i = 0; i < 14; i++)
      chk(vecs[i].name, padded_img[vecs[i].r][vecs[i].c], vecs[i].exp);

    // HOLD ignores incoming pixels, including sof.
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'hFF;
      pix_sof   = (i == 0);
      @(posedge clk);
      #1;
      chk("hold_frame", frame_diff(), 0);
      chk("hold_valid", img_valid, 1);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    chk("hold_sof_err", sof_err, 0);
    release_frame();
    chk("done_img_valid", img_valid, 0);
    chk("done_pix_ready", pix_ready, 1);
    chk("done_frame", frame_diff(), 0);
    release_frame();
    chk("done_in_load_ready", pix_ready, 1);
    chk("done_in_load_valid", img_valid, 0);

    // Randomly gated valid, no sof: position (0,0) starts the frame.
    k = 0;
    cycles = 0;
    ready_drop = 0;
    while (k < 25 && cycles < 500) begin
      v = 1'($urandom_range(0, 1));
      pix_valid = v;
      pix_in    = 8'(100 + k);
      @(posedge clk);
      #1;
      cycles++;
      if (v) begin
        k++;
        if (k == 3) chk("retain_prev_p55", padded_img[5][5], 8'd25);
      end
      if (k < 25 && !pix_ready) ready_drop++;
    end
    pix_valid = 1'b0;
    chk("rand_complete", k, 25);
    chk("rand_ready_high", ready_drop, 0);
    chk("rand_img_valid", img_valid, 1);
    chk("rand_frame_cnt", frame_cnt, 2);
    set_frame(100, 1'b0);
    chk("rand_frame", frame_diff(), 0);
    release_frame();

    // Restart after 7 pixels.
    for (int i = 0; i < 7; i++) send(8'(200 + i), 1'b0);
    send(8'h40, 1'b1);
    chk("restart_sof_err", sof_err, 1);
    chk("restart_p11", padded_img[1][1], 8'h40);
    chk("restart_keep_p22", padded_img[2][2], 8'd206);
    chk("restart_frame_cnt", frame_cnt, 2);
    for (int i = 1; i <= 24; i++) begin
      send(8'(8'h40 + i), 1'b0);
      if (i == 1) chk("restart_sof_err_pulse", sof_err, 0);
      if (i == 23) chk("restart_pre_valid", img_valid, 0);
    end
    chk("restart_img_valid", img_valid, 1);
    chk("restart_frame_cnt_inc", frame_cnt, 3);
    set_frame(8'h40, 1'b0);
    chk("restart_frame", frame_diff(), 0);
    release_frame();

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 12; i++) send(8'd7, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    set_frame(0, 1'b1);
    chk("arst_frame", frame_diff(), 0);
    chk("arst_img_valid", img_valid, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_sof_err", sof_err, 0);
    chk("arst_pix_ready", pix_ready, 1);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      send(8'(i), 1'b0);
      if (i == 1) chk("arst_first_p11", padded_img[1][1], 8'd1);
    end
    set_frame(1, 1'b0);
    chk("arst_refill_frame", frame_diff(), 0);
    chk("arst_refill_cnt", frame_cnt, 1);
    chk("arst_refill_valid", img_valid, 1);

    // Reset while holding a frame.
    #3;
    rst = 1'b1;
    #1;
    set_frame(0, 1'b1);
    chk("hold_rst_valid", img_valid, 0);
    chk("hold_rst_ready", pix_ready, 1);
    chk("hold_rst_frame", frame_diff(), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // frame_cnt wrap over 256 completions.
    errs = 0;
    for (int f = 1; f <= 255; f++) begin
      if (f > 1) release_frame();
      for (int i = 0; i < 25; i++) send(8'(f), 1'b0);
      if (frame_cnt !== 8'(f)) errs++;
    end
    chk("wrap_count_track", errs, 0);
    chk("wrap_pre_255", frame_cnt, 255);
    release_frame();
    for (int i = 0; i < 25; i++) send(8'd9, 1'b0);
    chk("wrap_to_zero", frame_cnt, 0);
    chk("wrap_img_valid", img_valid, 1);
    chk("wrap_p33", padded_img[3][3], 8'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
